cp0: RTL and testbench

Coprocessor-0 register file and exception/interrupt arbiter for the P8 pipelined MIPS core. It sits at the MEM stage, alongside the data memory. It consumes the `cp0we` write strobe and the M-stage instruction's operands. It decides, once per cycle, whether the M-stage instruction is replaced by an exception/interrupt entry, and drives the flush/redirect request and the `mfc0` read data (the `m_realdmM_sel = 2'b01` path).

---
 rtl/cp0_pkg.sv | 37 +++
 rtl/cp0_sync2.sv | 34 +++
 rtl/cp0.sv | 116 +++++++++++
 tb/tb_cp0.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared CP0 constants: register numbers, field positions,
//               exception codes and handler address.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] c_reg_sr    = 5'd12;
  localparam logic [4:0] c_reg_cause = 5'd13;
  localparam logic [4:0] c_reg_epc   = 5'd14;
  localparam logic [4:0] c_reg_prid  = 5'd15;

  // Field bit positions
  localparam int c_ie_bit  = 0;
  localparam int c_exl_bit = 1;
  localparam int c_im_lo   = 10;
  localparam int c_ip_lo   = 10;
  localparam int c_exc_lo  = 2;
  localparam int c_bd_bit  = 31;

  // ExcCode values
  localparam logic [4:0] c_exc_int  = 5'd0;
  localparam logic [4:0] c_exc_adel = 5'd4;
  localparam logic [4:0] c_exc_ades = 5'd5;
  localparam logic [4:0] c_exc_ri   = 5'd10;
  localparam logic [4:0] c_exc_ov   = 5'd12;

  // Exception/interrupt entry point
  localparam logic [31:0] c_handler_addr = 32'h0000_4180;

endpackage

`default_nettype wire

// File: rtl/cp0_sync2.sv
// ============================================================================
// Module      : cp0_sync2
// Description : Parameterised-width two-flop synchroniser, async active-low reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cp0_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

`default_nettype wire

// File: rtl/cp0.sv
// ============================================================================
// Module      : cp0
// Description : CP0 register file (SR/Cause/EPC/PRId) and exception/interrupt
//               arbiter for the M stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h5038_0001,
  parameter int          IM_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  input  logic [31:0]     din,
  input  logic            we,
  input  logic [31:0]     pc,
  input  logic            bd,
  input  logic [4:0]      excode,
  input  logic            exl_clr,
  input  logic [IM_W-1:0] hwint,
  output logic            intreq,
  output logic [31:0]     epc,
  output logic [31:0]     dout
);

  logic [IM_W-1:0] r_im;
  logic            r_exl;
  logic            r_ie;
  logic [IM_W-1:0] r_ip;
  logic            r_bd;
  logic [4:0]      r_exccode;
  logic [31:0]     r_epc;

  logic [IM_W-1:0] w_hwint_sync;
  logic            w_int_req;
  logic            w_exc_req;
  logic [31:0]     w_victim_pc;
  logic [31:0]     w_sr;
  logic [31:0]     w_cause;

  cp0_sync2 #(.WIDTH(IM_W)) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (hwint),
    .q     (w_hwint_sync)
  );

  assign w_int_req   = r_ie & ~r_exl & (|(r_im & r_ip));
  assign w_exc_req   = (excode != 5'd0) & ~r_exl;
  assign intreq      = w_int_req | w_exc_req;
  assign w_victim_pc = (bd ? (pc - 32'd4) : pc) & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_ip      <= '0;
      r_bd      <= 1'b0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      // IP is a level view of the synchronised lines, never latched
      r_ip <= w_hwint_sync;
      if (intreq) begin
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? c_exc_int : excode;
        r_bd      <= bd;
        r_epc     <= w_victim_pc;
      end else begin
        if (we && (a2 == c_reg_sr)) begin
          r_im  <= din[c_im_lo +: IM_W];
          r_ie  <= din[c_ie_bit];
          r_exl <= exl_clr ? 1'b0 : din[c_exl_bit];
        end else if (exl_clr) begin
          r_exl <= 1'b0;
        end
        if (we && (a2 == c_reg_epc)) begin
          r_epc <= {din[31:2], 2'b00};
        end
      end
    end
  end

  always_comb begin
    w_sr                    = 32'd0;
    w_sr[c_im_lo +: IM_W]   = r_im;
    w_sr[c_exl_bit]         = r_exl;
    w_sr[c_ie_bit]          = r_ie;
    w_cause                 = 32'd0;
    w_cause[c_bd_bit]       = r_bd;
    w_cause[c_ip_lo +: IM_W] = r_ip;
    w_cause[c_exc_lo +: 5]  = r_exccode;
  end

  always_comb begin
    dout = 32'd0;
    case (a1)
      c_reg_sr:    dout = w_sr;
      c_reg_cause: dout = w_cause;
      c_reg_epc:   dout = r_epc;
      c_reg_prid:  dout = PRID;
      default:     dout = 32'd0;
    endcase
  end

  assign epc = r_epc;

endmodule

`default_nettype wire

// File: tb/tb_cp0.sv
// ============================================================================
// Module      : tb_cp0
// Description : Directed self-checking bench for cp0.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cp0;

  localparam logic [31:0] PRID = 32'h5038_0001;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  excode;
  logic        exl_clr;
  logic [5:0]  hwint;
  logic        intreq;
  logic [31:0] epc;
  logic [31:0] dout;

  int n_vec;
  int n_err;

  cp0 #(.PRID(PRID), .IM_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a1      (a1),
    .a2      (a2),
    .din     (din),
    .we      (we),
    .pc      (pc),
    .bd      (bd),
    .excode  (excode),
    .exl_clr (exl_clr),
    .hwint   (hwint),
    .intreq  (intreq),
    .epc     (epc),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks happen here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] r, input logic [31:0] exp);
    a1 = r;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    we = 1'b1; a2 = r; din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic clr_exl();
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; a1 = 5'd0; a2 = 5'd0; din = 32'd0; we = 1'b0;
    pc = 32'd0; bd = 1'b0; excode = 5'd0; exl_clr = 1'b0; hwint = 6'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    rd("rst_prid", 5'd15, PRID);
    rd("rd_other", 5'd5, 32'd0);
    check("rst_intreq", {31'd0, intreq}, 32'd0);

    // Enable IM[0] + IE, then interrupt with 3-edge latency
    mtc0(5'd12, 32'h0000_0401);
    rd("sr_wr", 5'd12, 32'h0000_0401);
    pc = 32'h0000_1000; bd = 1'b0;
    hwint = 6'b000001;
    tick(); #1 check("int_lat1", {31'd0, intreq}, 32'd0);
    tick(); #1 check("int_lat2", {31'd0, intreq}, 32'd0);
    tick(); #1 check("int_lat3", {31'd0, intreq}, 32'd1);
    tick();
    check("int_masked", {31'd0, intreq}, 32'd0);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_cause", 5'd13, 32'h0000_0400);
    check("int_epc", epc, 32'h0000_1000);

    // eret with interrupt still pending re-raises intreq
    clr_exl();
    rd("eret_sr", 5'd12, 32'h0000_0401);
    check("eret_reraise", {31'd0, intreq}, 32'd1);
    tick();
    hwint = 6'd0;
    tick(); tick(); tick();
    rd("ip_clear", 5'd13, 32'h0000_0000);

    // Exception in delay slot
    clr_exl();
    excode = 5'd12; bd = 1'b1; pc = 32'h0000_3010;
    #1 check("exc_req", {31'd0, intreq}, 32'd1);
    tick();
    excode = 5'd0; bd = 1'b0;
    check("exc_epc", epc, 32'h0000_300C);
    rd("exc_cause", 5'd13, 32'h8000_0030);
    rd("exc_sr", 5'd12, 32'h0000_0403);

    // Interrupt beats a simultaneous exception; mtc0 in that cycle dropped
    clr_exl();
    hwint = 6'b000001;
    tick(); tick();
    #1 check("prio_pre", {31'd0, intreq}, 32'd0);
    tick();
    excode = 5'd4; pc = 32'h0000_2000; bd = 1'b0;
    we = 1'b1; a2 = 5'd14; din = 32'h0000_1234;
    #1 check("prio_req", {31'd0, intreq}, 32'd1);
    tick();
    we = 1'b0; excode = 5'd0;
    rd("prio_cause", 5'd13, 32'h0000_0400);
    check("prio_epc", epc, 32'h0000_2000);

    // mtc0 EPC clears low bits; writes to Cause ignored
    mtc0(5'd14, 32'h0000_3003);
    rd("epc_wr", 5'd14, 32'h0000_3000);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h0000_0400);

    // eret together with mtc0 SR: EXL cleared, IM/IE from din
    exl_clr = 1'b1;
    mtc0(5'd12, 32'h0000_0002);
    exl_clr = 1'b0;
    rd("eret_mtc0", 5'd12, 32'h0000_0000);
    check("eret_mtc0_int", {31'd0, intreq}, 32'd0);
    mtc0(5'd12, 32'h0000_0403);
    rd("sr_restore", 5'd12, 32'h0000_0403);

    // Async reset between edges while EXL=1 and IP!=0
    rst_n = 1'b0;
    #1;
    rd("arst_sr", 5'd12, 32'd0);
    rd("arst_cause", 5'd13, 32'd0);
    rd("arst_epc", 5'd14, 32'd0);
    check("arst_intreq", {31'd0, intreq}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
